// File: rtl/muldiv_pkg.sv
// Shared types and funct3 encodings for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply,
// trial-subtract-shift (restoring) for divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] trial;

  // Multiply: add multiplicand when lo[0] set, then shift right (carry enters hi).
  // Divide: shift left, subtract divisor, keep result and set quotient bit if no borrow.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_s = acc[2*WIDTH-1:WIDTH-1];
    trial = rem_s - {1'b0, operand};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute-stage RV32M unit: stalls the pipeline while an iterative radix-2
// datapath produces the result, presented for one cycle in DONE.
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MulDivE,
  input  logic [2:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             StallMD,
  output logic [WIDTH-1:0] MulDivResultE,
  output logic             MulDivDoneE
);

  localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic               negq_q, negr_q;

  logic               start, a_signed, b_signed, a_neg, b_neg;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_res, fix_res;
  logic [2*WIDTH-1:0] prod_fix;

  // Acceptance decode: operand magnitudes, sign flags and special-case results.
  always_comb begin
    start    = (state_q == IDLE) & MulDivE & ~FlushE;
    a_signed = (MulDivOpE == OP_MULH) | (MulDivOpE == OP_MULHSU) |
               (MulDivOpE == OP_DIV)  | (MulDivOpE == OP_REM);
    b_signed = (MulDivOpE == OP_MULH) | (MulDivOpE == OP_DIV) | (MulDivOpE == OP_REM);
    a_neg    = a_signed & SrcAE[WIDTH-1];
    b_neg    = b_signed & SrcBE[WIDTH-1];
    a_mag    = a_neg ? -SrcAE : SrcAE;
    b_mag    = b_neg ? -SrcBE : SrcBE;
    div_zero = MulDivOpE[2] & (SrcBE == '0);
    div_ovf  = ((MulDivOpE == OP_DIV) | (MulDivOpE == OP_REM)) &
               (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = MulDivOpE[1] ? SrcAE : '1;
    end else begin
      special_res = MulDivOpE[1] ? '0 : SrcAE;
    end
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc_q),
    .operand (b_q),
    .is_div  (op_q[2]),
    .acc_next(step_acc)
  );

  // Sign fix-up of the final iteration's accumulator into the architectural result.
  always_comb begin
    prod_fix = negq_q ? -step_acc : step_acc;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res = negq_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      default:                      fix_res = negr_q ? -step_acc[2*WIDTH-1:WIDTH]
                                                     : step_acc[2*WIDTH-1:WIDTH];
    endcase
  end

  // Next-state, counter, accumulator and result-load logic; flush overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = {{WIDTH{1'b0}}, a_mag};
          cnt_d = '0;
          if (div_zero | div_ovf) begin
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = fix_res;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FlushE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // FSM, iteration counter, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Operand/op latches: forwarded sources move during the stall, so capture once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      b_q    <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (start) begin
      op_q   <= MulDivOpE;
      b_q    <= b_mag;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end
  end

  assign MulDivResultE = result_q;
  assign MulDivDoneE   = (state_q == DONE);
  assign StallMD       = ~rst & (((state_q == IDLE) & MulDivE & ~FlushE) | (state_q == BUSY));

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Execute-stage RV32M multiply/divide unit. It consumes the E-stage operands and control that the decode-to-execute pipeline register presents, and drives the stall request back toward fetch, decode and that register. The stall holds the M-extension instruction in E while an iterative radix-2 datapath computes the result. The result is handed to the E-stage result mux in the cycle the stall releases.

## Interface
- `WIDTH`, default 32: operand/result width; also the iteration count.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `MulDivE` in 1: the instruction in E is RV32M (funct7 = 0000001, OP opcode).
- `MulDivOpE` in 3: funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE` in WIDTH: rs1 value after forwarding.
- `SrcBE` in WIDTH: rs2 value after forwarding.
- `FlushE` in 1: E-stage flush from the hazard unit.
- `StallMD` out 1: to the hazard unit; freezes PC, F/D and D/E registers.
- `MulDivResultE` out WIDTH: result, valid while `MulDivDoneE` = 1.
- `MulDivDoneE` out 1: result valid this cycle.

## Operation
- FSM states:
  - IDLE → BUSY on `MulDivE & ~FlushE`, normal case.
  - IDLE → DONE on `MulDivE & ~FlushE`, special-case divide.
  - BUSY → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE, unconditional. This prevents re-triggering on the same instruction still sitting in E.
  - Any state → IDLE on `FlushE`. Flush has priority over start and over completion.
- On acceptance (IDLE and start):
  - Latch `MulDivOpE`, `SrcAE`, `SrcBE`. Forwarded sources change during the stall, so the latched copies are used from here on.
  - Convert signed operands to magnitudes and record the result sign:
    - MULH: both operands signed.
    - MULHSU: A signed, B unsigned.
    - DIV/REM: both operands signed.
    - All others: unsigned.
- Multiply: 2·WIDTH-bit shift-add accumulator, one multiplier bit per BUSY cycle. Negate the full product if the sign flag is set.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- Divide: restoring, one quotient bit per BUSY cycle.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Special cases, detected at acceptance; the FSM skips BUSY and goes straight to DONE:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (A = most-negative, B = -1): DIV returns the most-negative value; REM returns 0.
- `MulDivResultE` is a register, loaded on entry to DONE. It holds its value until the next DONE entry.
- `MulDivDoneE` = (state == DONE).
- `StallMD` = (IDLE & `MulDivE` & ~`FlushE`) | BUSY. The IDLE term is combinational, so the instruction is held in the same cycle it is first seen. `StallMD` is low in DONE, so the pipeline advances and the E/M register captures the result.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, counter 0, operand and accumulator registers 0.
  - `MulDivResultE` = 0, `MulDivDoneE` = 0, `StallMD` = 0.
  - `StallMD` is forced to 0 while `rst` is high.
- Normal operation, acceptance in cycle T:
  - BUSY in cycles T+1 .. T+WIDTH.
  - DONE in cycle T+WIDTH+1; with WIDTH = 32 that is T+33.
  - `StallMD` is high in cycles T .. T+WIDTH (33 cycles).
- Special case: DONE in cycle T+1; `StallMD` is high in cycle T only.
- Back-to-back M instructions: the second is seen in IDLE at T+WIDTH+2 at the earliest. There is no lost or duplicated result.
- Flush in BUSY: the next cycle is IDLE, `StallMD` is 0 and `MulDivDoneE` never pulses.
- Flush in DONE: the FSM returns to IDLE. Downstream logic discards the result.
- Reset mid-operation: the operation is aborted and all outputs take their reset values immediately.
- Counter width: $clog2(WIDTH). It wraps to 0 on DONE entry.

## Structure
- Package `muldiv_pkg` holds:
  - typedef enum `muldiv_state_t` {IDLE, BUSY, DONE};
  - localparams for the eight funct3 codes.
- Optional sub-module `muldiv_step`: combinational single-iteration step (add-shift or trial-subtract-shift), instantiated once. Everything else (FSM, latches, sign fix-up) lives in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), accepted at T → `StallMD` high for T..T+32; `MulDivDoneE` pulses at T+33 with result 0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with done at T+1 and `StallMD` high only in T.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; done at T+1.
- Aborts:
  - `FlushE` in BUSY at iteration 10 → IDLE next cycle, `StallMD` = 0, no done pulse.
  - `rst` asserted mid-BUSY → all outputs 0 without waiting for a clock edge.
  - A following MUL 3 × 4 → 12.
